// File: rtl/coin_change_dispenser.sv
`timescale 1ns/1ps
// Greedy coin payout: a BCD change amount is paid as large coins first and then small coins,
// one timed hopper pulse per coin, each confirmed by a synchronised coin-drop edge.
module coin_change_dispenser #(
  parameter int PULSE_CYC   = 50000,
  parameter int ACK_TIMEOUT = 1000000,
  parameter int COIN_HI     = 5,
  parameter int COIN_LO     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] change_sw,
  input  logic [3:0] change_gw,
  input  logic       clr,
  input  logic       coin_sense,
  output logic       hopper_hi,
  output logic       hopper_lo,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [6:0] remaining,
  output logic [4:0] cnt_hi,
  output logic [2:0] cnt_lo
);

  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);
  localparam logic [6:0]    HI_VAL     = 7'(COIN_HI);
  localparam logic [6:0]    LO_VAL     = 7'(COIN_LO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SELECT,
    S_DRIVE,
    S_WAIT_ACK,
    S_DONE,
    S_FAULT
  } state_t;

  state_t          state;
  logic [3:0]      sw_q;
  logic [3:0]      gw_q;
  logic            coin_is_hi;
  logic            drop_seen;
  logic [PW-1:0]   pulse_cnt;
  logic [AW-1:0]   wait_cnt;
  logic [2:0]      sync_q;

  logic            drop;
  logic            digit_err;
  logic [6:0]      load_amt;
  logic [6:0]      coin_val;
  logic [6:0]      rem_after;
  logic            take_hi;

  // Two flops resynchronise the sensor; the third holds the previous sample for edge detection.
  // NOTE: flops use non-blocking assignments and reset asynchronously on rst_n low, so every
  // register (and hence every output) clears immediately, even in the middle of a hopper pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], coin_sense};
    end
  end

  assign drop      = sync_q[1] & ~sync_q[2];
  assign digit_err = (sw_q > 4'd9) || (gw_q > 4'd9);
  assign load_amt  = 7'(sw_q) * 7'd10 + 7'(gw_q);
  assign coin_val  = coin_is_hi ? HI_VAL : LO_VAL;
  assign rem_after = remaining - coin_val;
  assign take_hi   = remaining >= HI_VAL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sw_q       <= 4'd0;
      gw_q       <= 4'd0;
      coin_is_hi <= 1'b0;
      drop_seen  <= 1'b0;
      pulse_cnt  <= '0;
      wait_cnt   <= '0;
      hopper_hi  <= 1'b0;
      hopper_lo  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      remaining  <= 7'd0;
      cnt_hi     <= 5'd0;
      cnt_lo     <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sw_q  <= change_sw;
            gw_q  <= change_gw;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (digit_err) begin
            busy  <= 1'b0;
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            remaining <= load_amt;
            cnt_hi    <= 5'd0;
            cnt_lo    <= 3'd0;
            if (load_amt == 7'd0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_SELECT;
            end
          end
        end

        S_SELECT: begin
          coin_is_hi <= take_hi;
          hopper_hi  <= take_hi;
          hopper_lo  <= ~take_hi;
          pulse_cnt  <= '0;
          drop_seen  <= 1'b0;
          state      <= S_DRIVE;
        end

        S_DRIVE: begin
          // A coin can fall before the pulse ends; remember it for the acknowledge window.
          if (drop) drop_seen <= 1'b1;
          if (pulse_cnt == PULSE_LAST) begin
            hopper_hi <= 1'b0;
            hopper_lo <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_WAIT_ACK;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end

        S_WAIT_ACK: begin
          if (drop_seen || drop) begin
            remaining <= rem_after;
            if (coin_is_hi) cnt_hi <= cnt_hi + 5'd1;
            else            cnt_lo <= cnt_lo + 3'd1;
            if (rem_after == 7'd0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_SELECT;
            end
          end else if (wait_cnt == ACK_LAST) begin
            busy  <= 1'b0;
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        S_FAULT: begin
          if (clr) begin
            fault <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
`timescale 1ns/1ps
// Bench for coin_change_dispenser: vector table, random amounts against a greedy-payout model,
// and hand-written sequences for timing, timeout, double sensor edges and mid-pulse reset.
module tb_coin_change_dispenser;

  localparam int PULSE = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] change_sw;
  logic [3:0] change_gw;
  logic       clr;
  logic       coin_sense;
  logic       hopper_hi;
  logic       hopper_lo;
  logic       busy;
  logic       done;
  logic       fault;
  logic [6:0] remaining;
  logic [4:0] cnt_hi;
  logic [2:0] cnt_lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  coin_change_dispenser #(
    .PULSE_CYC   (PULSE),
    .ACK_TIMEOUT (TMO),
    .COIN_HI     (5),
    .COIN_LO     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .change_sw  (change_sw),
    .change_gw  (change_gw),
    .clr        (clr),
    .coin_sense (coin_sense),
    .hopper_hi  (hopper_hi),
    .hopper_lo  (hopper_lo),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .remaining  (remaining),
    .cnt_hi     (cnt_hi),
    .cnt_lo     (cnt_lo)
  );

  // Observed hopper pulses, done pulses and rule violations.
  typedef struct {
    logic is_hi;
    int   width;
  } pulse_t;

  pulse_t pulses[$];
  int hi_len   = 0;
  int lo_len   = 0;
  int done_cnt = 0;
  int viol     = 0;

  always @(negedge clk) begin
    if (hopper_hi) hi_len++;
    else if (hi_len > 0) begin
      pulses.push_back('{1'b1, hi_len});
      hi_len = 0;
    end
    if (hopper_lo) lo_len++;
    else if (lo_len > 0) begin
      pulses.push_back('{1'b0, lo_len});
      lo_len = 0;
    end
    if (done) done_cnt++;
    if ((hopper_hi && hopper_lo) || ((hopper_hi || hopper_lo) && remaining == 7'd0)) viol++;
  end

  // Coin-drop sensor: two cycles after a hopper pulse ends, emit edges_per_coin short pulses.
  int   sense_count    = 0;
  int   sense_limit    = 1 << 30;
  int   edges_per_coin = 1;
  logic drv_prev       = 1'b0;
  logic drv_now;

  initial begin
    coin_sense = 1'b0;
    forever begin
      @(negedge clk);
      drv_now = hopper_hi | hopper_lo;
      if (drv_prev && !drv_now && sense_count < sense_limit) begin
        sense_count++;
        repeat (2) @(negedge clk);
        for (int e = 0; e < edges_per_coin; e++) begin
          coin_sense = 1'b1;
          @(negedge clk);
          coin_sense = 1'b0;
          @(negedge clk);
        end
        drv_now = hopper_hi | hopper_lo;
      end
      drv_prev = drv_now;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] sw, input logic [3:0] gw);
    @(negedge clk);
    change_sw = sw;
    change_gw = gw;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ended);
    ended = 1'b0;
    for (int i = 0; i < budget && !ended; i++) begin
      @(negedge clk);
      if (done || fault) ended = 1'b1;
    end
  endtask

  task automatic clear_fault();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_pulses(input string tag, input int pb, input int exp_hi, input int exp_lo);
    int n;
    int bad;
    n   = pulses.size() - pb;
    bad = 0;
    check({tag, " pulse count"}, n, exp_hi + exp_lo);
    for (int i = 0; i < n && i < exp_hi + exp_lo; i++) begin
      if (pulses[pb + i].is_hi !== (i < exp_hi) || pulses[pb + i].width != PULSE) bad++;
    end
    check({tag, " pulse order/width errors"}, bad, 0);
  endtask

  // Full transaction: expected coins come from the greedy rule hi = amt/5, lo = amt%5.
  task automatic run_txn(input string tag, input logic [3:0] sw, input logic [3:0] gw,
                         input bit exp_fault, input int exp_hi, input int exp_lo);
    int pb;
    int db;
    bit ended;
    pb = pulses.size();
    db = done_cnt;
    do_start(sw, gw);
    wait_end(3000, ended);
    check({tag, " finished"}, ended, 1);
    repeat (12) @(negedge clk);
    check({tag, " fault"}, fault, exp_fault);
    check({tag, " done pulses"}, done_cnt - db, exp_fault ? 0 : 1);
    check({tag, " busy after"}, busy, 0);
    if (!exp_fault) begin
      check({tag, " cnt_hi"}, cnt_hi, exp_hi);
      check({tag, " cnt_lo"}, cnt_lo, exp_lo);
      check({tag, " remaining"}, remaining, 0);
    end
    check_pulses(tag, pb, exp_fault ? 0 : exp_hi, exp_fault ? 0 : exp_lo);
    if (fault) begin
      clear_fault();
      check({tag, " fault cleared"}, fault, 0);
    end
  endtask

  typedef struct {
    logic [3:0] sw;
    logic [3:0] gw;
    bit         f;
    int         hi;
    int         lo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  pb;
    int  db;
    int  k;
    int  amt;
    bit  ended;
    bit  found;
    logic [3:0] rsw;
    logic [3:0] rgw;

    vecs[0] = '{4'd2, 4'd3, 1'b0, 4, 3};
    vecs[1] = '{4'd0, 4'd0, 1'b0, 0, 0};
    vecs[2] = '{4'hF, 4'hF, 1'b1, 0, 0};
    vecs[3] = '{4'd0, 4'd4, 1'b0, 0, 4};
    vecs[4] = '{4'd1, 4'd0, 1'b0, 2, 0};
    vecs[5] = '{4'd9, 4'd9, 1'b0, 19, 4};
    vecs[6] = '{4'd0, 4'hA, 1'b1, 0, 0};
    vecs[7] = '{4'd3, 4'd7, 1'b0, 7, 2};

    rst_n     = 1'b0;
    start     = 1'b0;
    clr       = 1'b0;
    change_sw = 4'd0;
    change_gw = 4'd0;
    repeat (3) @(negedge clk);
    check("reset outputs", {hopper_hi, hopper_lo, busy, done, fault, remaining, cnt_hi, cnt_lo}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].sw, vecs[i].gw, vecs[i].f, vecs[i].hi, vecs[i].lo);
    end

    // Zero change: done two cycles after start, busy for the single LOAD cycle.
    pb = pulses.size();
    @(negedge clk);
    change_sw = 4'd0;
    change_gw = 4'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero busy in load", busy, 1);
    check("zero done early", done, 0);
    @(negedge clk);
    check("zero done at n+2", done, 1);
    check("zero busy at n+2", busy, 0);
    @(negedge clk);
    check("zero done one cycle", done, 0);
    check("zero no pulses", pulses.size() - pb, 0);

    // Sensor stops after the first coin: acknowledge timeout on the second.
    repeat (4) @(negedge clk);
    sense_limit = sense_count + 1;
    do_start(4'd0, 4'd7);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (hopper_lo) found = 1'b1;
    end
    check("timeout lo pulse seen", found, 1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!hopper_lo) found = 1'b1;
    end
    k = 0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      k++;
      if (fault) found = 1'b1;
    end
    check("timeout fault latency", k, TMO);
    check("timeout cnt_hi", cnt_hi, 1);
    check("timeout cnt_lo", cnt_lo, 0);
    check("timeout remaining", remaining, 2);
    check("timeout busy", busy, 0);
    sense_limit = 1 << 30;
    do_start(4'd0, 4'd1);
    check("start ignored in fault", busy, 0);
    clear_fault();
    check("timeout fault cleared", fault, 0);
    repeat (4) @(negedge clk);

    // Double sensor edges per coin and a second start in the middle of the payout.
    edges_per_coin = 2;
    pb = pulses.size();
    db = done_cnt;
    do_start(4'd9, 4'd9);
    repeat (30) @(negedge clk);
    check("second start while busy", busy, 1);
    do_start(4'd0, 4'd1);
    wait_end(3000, ended);
    check("double finished", ended, 1);
    repeat (12) @(negedge clk);
    check("double cnt_hi", cnt_hi, 19);
    check("double cnt_lo", cnt_lo, 4);
    check("double remaining", remaining, 0);
    check("double done pulses", done_cnt - db, 1);
    check_pulses("double", pb, 19, 4);
    repeat (20) @(negedge clk);
    check("second start not queued", busy, 0);
    edges_per_coin = 1;

    // Reset in the middle of a hopper pulse.
    do_start(4'd0, 4'd9);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (hopper_hi) found = 1'b1;
    end
    check("reset test drive seen", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset drops hopper async", hopper_hi, 0);
    check("reset clears outputs", {hopper_hi, hopper_lo, busy, done, fault, remaining, cnt_hi, cnt_lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle after reset", busy, 0);
    run_txn("post reset", 4'd0, 4'd6, 1'b0, 1, 1);

    // Random amounts, occasionally with an invalid digit.
    for (int t = 0; t < 20; t++) begin
      rsw = 4'($urandom_range(0, 9));
      rgw = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) rsw = 4'($urandom_range(10, 15));
      amt = 10 * int'(rsw) + int'(rgw);
      run_txn($sformatf("rand%0d amt=%0d", t, amt), rsw, rgw,
              (rsw > 4'd9) || (rgw > 4'd9), amt / 5, amt % 5);
    end

    check("hopper rule violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
